// File: rtl/keypad_scan_ctrl_if.sv
// Key event bus from the keypad scanner to downstream key consumers.
interface keypad_scan_ctrl_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        input key_code,
        input key_valid,
        input key_held
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scan controller: walks the columns, samples synchronised rows,
// classifies each full frame and debounces frame results into key events.
module keypad_scan_ctrl #(
    parameter int unsigned CLK_DIV  = 1000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_scan_en,
    input  logic [3:0]                i_row_n,
    output logic [3:0]                o_col_n,
    keypad_scan_ctrl_if.master        key_if
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned STB_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE);

    typedef enum logic {
        ST_OFF  = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_ONE   = 2'd1,
        RES_MULTI = 2'd2
    } res_e;

    scan_state_e      r_state,      w_nxt_state;
    logic [DIV_W-1:0] r_div_cnt,    w_nxt_div_cnt;
    logic [1:0]       r_col_idx,    w_nxt_col_idx;
    logic [1:0]       r_hit_cnt,    w_nxt_hit_cnt;
    logic [3:0]       r_first_code, w_nxt_first_code;
    res_e             r_prev_res,   w_nxt_prev_res;
    logic [3:0]       r_prev_code,  w_nxt_prev_code;
    logic [STB_W-1:0] r_stable,     w_nxt_stable;
    logic [3:0]       r_key_code,   w_nxt_key_code;
    logic             r_key_valid,  w_nxt_key_valid;
    logic             r_key_held,   w_nxt_key_held;
    logic [3:0]       r_col_n,      w_nxt_col_n;
    logic [3:0]       r_row_s1;
    logic [3:0]       r_row_s2;

    logic [3:0]       w_hits;
    logic             w_one_row;
    logic             w_multi_row;
    logic [1:0]       w_row_idx;
    logic [1:0]       w_acc_cnt;
    logic [3:0]       w_acc_code;
    res_e             w_res;
    logic             w_same;
    logic [STB_W-1:0] w_stable_upd;
    logic             w_settled;

    assign o_col_n          = r_col_n;
    assign key_if.key_code  = r_key_code;
    assign key_if.key_valid = r_key_valid;
    assign key_if.key_held  = r_key_held;

    // Two-flop synchroniser for the asynchronous row lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_s1 <= 4'b1111;
            r_row_s2 <= 4'b1111;
        end else begin
            r_row_s1 <= i_row_n;
            r_row_s2 <= r_row_s1;
        end
    end

    // Classify the current column sample and fold it into the frame accumulator.
    always_comb begin
        w_hits      = ~r_row_s2;
        w_one_row   = (w_hits != 4'd0) && ((w_hits & (w_hits - 4'd1)) == 4'd0);
        w_multi_row = (w_hits != 4'd0) && !w_one_row;
        w_acc_cnt   = r_hit_cnt;
        w_acc_code  = r_first_code;
        case (w_hits)
            4'b0010: w_row_idx = 2'd1;
            4'b0100: w_row_idx = 2'd2;
            4'b1000: w_row_idx = 2'd3;
            default: w_row_idx = 2'd0;
        endcase
        if (w_multi_row) begin
            w_acc_cnt = 2'd2;
        end else if (w_one_row) begin
            if (r_hit_cnt == 2'd0) begin
                w_acc_cnt  = 2'd1;
                w_acc_code = {w_row_idx, r_col_idx};
            end else begin
                w_acc_cnt = 2'd2;
            end
        end
    end

    // Frame result and the debounce count it would produce at frame end.
    always_comb begin
        if (w_acc_cnt == 2'd0) begin
            w_res = RES_NONE;
        end else if (w_acc_cnt == 2'd1) begin
            w_res = RES_ONE;
        end else begin
            w_res = RES_MULTI;
        end
        w_same = (w_res == r_prev_res) && ((w_res != RES_ONE) || (w_acc_code == r_prev_code));
        if (!w_same) begin
            w_stable_upd = STB_W'(1);
        end else if (r_stable == STB_MAX) begin
            w_stable_upd = r_stable;
        end else begin
            w_stable_upd = r_stable + STB_W'(1);
        end
        w_settled = (w_stable_upd == STB_MAX);
    end

    // Scan sequencing, frame-end debounce and key acceptance.
    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_div_cnt    = r_div_cnt;
        w_nxt_col_idx    = r_col_idx;
        w_nxt_hit_cnt    = r_hit_cnt;
        w_nxt_first_code = r_first_code;
        w_nxt_prev_res   = r_prev_res;
        w_nxt_prev_code  = r_prev_code;
        w_nxt_stable     = r_stable;
        w_nxt_key_code   = r_key_code;
        w_nxt_key_held   = r_key_held;
        w_nxt_key_valid  = 1'b0;
        w_nxt_col_n      = 4'b1111;

        case (r_state)
            ST_OFF: begin
                if (i_scan_en) begin
                    w_nxt_state = ST_SCAN;
                    w_nxt_col_n = 4'b1110;
                end
            end
            ST_SCAN: begin
                if (!i_scan_en) begin
                    w_nxt_state      = ST_OFF;
                    w_nxt_div_cnt    = '0;
                    w_nxt_col_idx    = 2'd0;
                    w_nxt_hit_cnt    = 2'd0;
                    w_nxt_first_code = 4'd0;
                end else begin
                    if (r_div_cnt == DIV_LAST) begin
                        w_nxt_div_cnt = '0;
                        w_nxt_col_idx = r_col_idx + 2'd1;
                        if (r_col_idx == 2'd3) begin
                            w_nxt_hit_cnt    = 2'd0;
                            w_nxt_first_code = 4'd0;
                            w_nxt_stable     = w_stable_upd;
                            if (!w_same) begin
                                w_nxt_prev_res  = w_res;
                                w_nxt_prev_code = w_acc_code;
                            end
                            if (w_settled && (w_res == RES_ONE) && !r_key_held) begin
                                w_nxt_key_code  = w_acc_code;
                                w_nxt_key_held  = 1'b1;
                                w_nxt_key_valid = 1'b1;
                            end else if (w_settled && (w_res == RES_NONE) && r_key_held) begin
                                w_nxt_key_held = 1'b0;
                            end
                        end else begin
                            w_nxt_hit_cnt    = w_acc_cnt;
                            w_nxt_first_code = w_acc_code;
                        end
                    end else begin
                        w_nxt_div_cnt = r_div_cnt + DIV_W'(1);
                    end
                    w_nxt_col_n = ~(4'b0001 << w_nxt_col_idx);
                end
            end
            default: begin
                w_nxt_state = ST_OFF;
            end
        endcase
    end

    // State register; reset overrides every other update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_OFF;
            r_div_cnt    <= '0;
            r_col_idx    <= 2'd0;
            r_hit_cnt    <= 2'd0;
            r_first_code <= 4'd0;
            r_prev_res   <= RES_NONE;
            r_prev_code  <= 4'd0;
            r_stable     <= '0;
            r_key_code   <= 4'd0;
            r_key_valid  <= 1'b0;
            r_key_held   <= 1'b0;
            r_col_n      <= 4'b1111;
        end else begin
            r_state      <= w_nxt_state;
            r_div_cnt    <= w_nxt_div_cnt;
            r_col_idx    <= w_nxt_col_idx;
            r_hit_cnt    <= w_nxt_hit_cnt;
            r_first_code <= w_nxt_first_code;
            r_prev_res   <= w_nxt_prev_res;
            r_prev_code  <= w_nxt_prev_code;
            r_stable     <= w_nxt_stable;
            r_key_code   <= w_nxt_key_code;
            r_key_valid  <= w_nxt_key_valid;
            r_key_held   <= w_nxt_key_held;
            r_col_n      <= w_nxt_col_n;
        end
    end

endmodule
